// File: rtl/branch_hazard_ctrl_if.sv
// Bundle between the ID-stage branch logic, the equality comparator and the
// hazard/forwarding/redirect controls of the pipeline.
interface branch_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             br_valid;
  logic             bne;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [31:0]      br_target;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_reg_write;
  logic             mem_mem_read;
  logic [4:0]       mem_rd;
  logic             flush_in;
  logic             cmp_out;

  logic             cmp_bne;
  logic             fwd_a_sel;
  logic             fwd_b_sel;
  logic             stall;
  logic             pc_sel;
  logic [31:0]      pc_target;
  logic             flush_if;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;
  logic             last_taken;

  modport master (
    output br_valid, bne, rs, rt, br_target,
    output ex_reg_write, ex_mem_read, ex_rd,
    output mem_reg_write, mem_mem_read, mem_rd,
    output flush_in, cmp_out,
    input  cmp_bne, fwd_a_sel, fwd_b_sel, stall, pc_sel, pc_target, flush_if,
    input  br_count, taken_count, last_taken
  );

  modport slave (
    input  br_valid, bne, rs, rt, br_target,
    input  ex_reg_write, ex_mem_read, ex_rd,
    input  mem_reg_write, mem_mem_read, mem_rd,
    input  flush_in, cmp_out,
    output cmp_bne, fwd_a_sel, fwd_b_sel, stall, pc_sel, pc_target, flush_if,
    output br_count, taken_count, last_taken
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch resolution: hazard stall, operand forwarding select, PC
// redirect / IF-ID flush and saturating branch statistics.
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  branch_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic             last_taken_q, last_taken_d;

  logic             hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic [1:0]       need_a, need_b, need;
  logic             fwd_a_raw, fwd_b_raw;
  logic             stall_c, pc_sel_c, flush_if_c, fwd_a_c, fwd_b_c;
  logic [31:0]      pc_target_c;

  function automatic logic reg_hit(input logic [4:0] src, input logic wr,
                                   input logic [4:0] rd);
    return (src != 5'd0) && wr && (rd == src);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // An EX producer is the youngest and dominates any MEM match on the same register.
  always_comb begin
    hit_ex_a  = reg_hit(bus.rs, bus.ex_reg_write, bus.ex_rd);
    hit_ex_b  = reg_hit(bus.rt, bus.ex_reg_write, bus.ex_rd);
    hit_mem_a = reg_hit(bus.rs, bus.mem_reg_write, bus.mem_rd);
    hit_mem_b = reg_hit(bus.rt, bus.mem_reg_write, bus.mem_rd);

    need_a = hit_ex_a ? (bus.ex_mem_read ? 2'd2 : 2'd1)
                      : ((hit_mem_a && bus.mem_mem_read) ? 2'd1 : 2'd0);
    need_b = hit_ex_b ? (bus.ex_mem_read ? 2'd2 : 2'd1)
                      : ((hit_mem_b && bus.mem_mem_read) ? 2'd1 : 2'd0);
    need   = (need_a > need_b) ? need_a : need_b;

    fwd_a_raw = !hit_ex_a && hit_mem_a && !bus.mem_mem_read;
    fwd_b_raw = !hit_ex_b && hit_mem_b && !bus.mem_mem_read;
  end

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    last_taken_d  = last_taken_q;
    stall_c       = 1'b0;
    pc_sel_c      = 1'b0;
    flush_if_c    = 1'b0;
    fwd_a_c       = 1'b0;
    fwd_b_c       = 1'b0;
    pc_target_c   = 32'd0;

    if (state_q == STALL) begin
      stall_c = 1'b1;
      if (bus.flush_in) begin
        state_d     = IDLE;
        stall_cnt_d = 2'd0;
      end else begin
        stall_cnt_d = (stall_cnt_q == 2'd0) ? 2'd0 : 2'(stall_cnt_q - 2'd1);
        // The last counted stall cycle hands back to IDLE for re-evaluation.
        if (stall_cnt_q <= 2'd1) state_d = IDLE;
      end
    end else if (bus.flush_in) begin
      stall_cnt_d = 2'd0;
      if (bus.br_valid) begin
        fwd_a_c = fwd_a_raw;
        fwd_b_c = fwd_b_raw;
      end
    end else if (bus.br_valid) begin
      fwd_a_c = fwd_a_raw;
      fwd_b_c = fwd_b_raw;
      if (need != 2'd0) begin
        stall_c     = 1'b1;
        stall_cnt_d = 2'(need - 2'd1);
        if (need == 2'd2) state_d = STALL;
      end else begin
        pc_sel_c      = bus.cmp_out;
        flush_if_c    = bus.cmp_out;
        pc_target_c   = bus.br_target;
        br_count_d    = sat_inc(br_count_q);
        if (bus.cmp_out) taken_count_d = sat_inc(taken_count_q);
        last_taken_d  = bus.cmp_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      stall_cnt_q   <= 2'd0;
      br_count_q    <= '0;
      taken_count_q <= '0;
      last_taken_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
      last_taken_q  <= last_taken_d;
    end
  end

  // Combinational controls are held at their reset values while rst_n is low.
  assign bus.cmp_bne     = bus.bne;
  assign bus.stall       = rst_n & stall_c;
  assign bus.pc_sel      = rst_n & pc_sel_c;
  assign bus.flush_if    = rst_n & flush_if_c;
  assign bus.fwd_a_sel   = rst_n & fwd_a_c;
  assign bus.fwd_b_sel   = rst_n & fwd_b_c;
  assign bus.pc_target   = rst_n ? pc_target_c : 32'd0;
  assign bus.br_count    = br_count_q;
  assign bus.taken_count = taken_count_q;
  assign bus.last_taken  = last_taken_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; a narrow-counter twin shares the
// stimulus so counter saturation is reachable in a few cycles.
module tb_branch_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_hazard_ctrl_if #(.CNT_W(16)) bus ();
  branch_hazard_ctrl_if #(.CNT_W(3))  sbus ();

  branch_hazard_ctrl #(.CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  branch_hazard_ctrl #(.CNT_W(3))  dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus));

  assign sbus.br_valid      = bus.br_valid;
  assign sbus.bne           = bus.bne;
  assign sbus.rs            = bus.rs;
  assign sbus.rt            = bus.rt;
  assign sbus.br_target     = bus.br_target;
  assign sbus.ex_reg_write  = bus.ex_reg_write;
  assign sbus.ex_mem_read   = bus.ex_mem_read;
  assign sbus.ex_rd         = bus.ex_rd;
  assign sbus.mem_reg_write = bus.mem_reg_write;
  assign sbus.mem_mem_read  = bus.mem_mem_read;
  assign sbus.mem_rd        = bus.mem_rd;
  assign sbus.flush_in      = bus.flush_in;
  assign sbus.cmp_out       = bus.cmp_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog bench did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.br_valid = 0; bus.bne = 0; bus.rs = 0; bus.rt = 0; bus.br_target = 0;
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    bus.mem_reg_write = 0; bus.mem_mem_read = 0; bus.mem_rd = 0;
    bus.flush_in = 0; bus.cmp_out = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.pc_sel !== 1'b0 || bus.flush_if !== 1'b0) begin failures++; $display("FAIL reset_pcsel got=%0b%0b exp=00", bus.pc_sel, bus.flush_if); end
    checks++; if (bus.pc_target !== 32'd0) begin failures++; $display("FAIL reset_target got=%0h exp=0", bus.pc_target); end
    checks++; if (bus.br_count !== 16'd0 || bus.taken_count !== 16'd0 || bus.last_taken !== 1'b0) begin
      failures++; $display("FAIL reset_counts got=%0d/%0d/%0b exp=0/0/0", bus.br_count, bus.taken_count, bus.last_taken); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_no_hazard();
    bus.br_valid = 1; bus.bne = 0; bus.rs = 3; bus.rt = 4; bus.cmp_out = 1; bus.br_target = 32'h40;
    #2;
    checks++; if (bus.pc_sel !== 1'b1 || bus.flush_if !== 1'b1) begin failures++; $display("FAIL nohaz_redirect got=%0b%0b exp=11", bus.pc_sel, bus.flush_if); end
    checks++; if (bus.pc_target !== 32'h40) begin failures++; $display("FAIL nohaz_target got=%0h exp=40", bus.pc_target); end
    checks++; if (bus.stall !== 1'b0 || bus.cmp_bne !== 1'b0) begin failures++; $display("FAIL nohaz_stall got=%0b bne=%0b exp=0/0", bus.stall, bus.cmp_bne); end
    tick();
    clear_inputs();
    #2;
    checks++; if (bus.br_count !== 16'd1 || bus.taken_count !== 16'd1 || bus.last_taken !== 1'b1) begin
      failures++; $display("FAIL nohaz_counts got=%0d/%0d/%0b exp=1/1/1", bus.br_count, bus.taken_count, bus.last_taken); end
    checks++; if (bus.pc_sel !== 1'b0 || bus.pc_target !== 32'd0) begin failures++; $display("FAIL idle_outputs got=%0b/%0h exp=0/0", bus.pc_sel, bus.pc_target); end
  endtask

  task automatic test_ex_alu();
    bus.br_valid = 1; bus.rs = 3; bus.rt = 4; bus.cmp_out = 1; bus.br_target = 32'h80;
    bus.ex_reg_write = 1; bus.ex_rd = 3;
    #2;
    checks++; if (bus.stall !== 1'b1 || bus.pc_sel !== 1'b0) begin failures++; $display("FAIL exalu_stall got=%0b/%0b exp=1/0", bus.stall, bus.pc_sel); end
    tick();
    bus.ex_reg_write = 0; bus.ex_rd = 0; bus.mem_reg_write = 1; bus.mem_rd = 3;
    #2;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL exalu_release got=%0b exp=0", bus.stall); end
    checks++; if (bus.fwd_a_sel !== 1'b1 || bus.fwd_b_sel !== 1'b0) begin failures++; $display("FAIL exalu_fwd got=%0b%0b exp=10", bus.fwd_a_sel, bus.fwd_b_sel); end
    checks++; if (bus.pc_sel !== 1'b1 || bus.pc_target !== 32'h80) begin failures++; $display("FAIL exalu_resolve got=%0b/%0h exp=1/80", bus.pc_sel, bus.pc_target); end
    tick();
    clear_inputs();
    checks++; if (bus.br_count !== 16'd2 || bus.taken_count !== 16'd2) begin failures++; $display("FAIL exalu_counts got=%0d/%0d exp=2/2", bus.br_count, bus.taken_count); end
  endtask

  task automatic test_ex_load();
    bus.br_valid = 1; bus.bne = 1; bus.rs = 5; bus.rt = 4; bus.cmp_out = 0; bus.br_target = 32'hC0;
    bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_rd = 4;
    #2;
    checks++; if (bus.stall !== 1'b1 || bus.cmp_bne !== 1'b1) begin failures++; $display("FAIL load_stall0 got=%0b bne=%0b exp=1/1", bus.stall, bus.cmp_bne); end
    tick();
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    bus.mem_reg_write = 1; bus.mem_mem_read = 1; bus.mem_rd = 4;
    #2;
    checks++; if (bus.stall !== 1'b1 || bus.pc_sel !== 1'b0) begin failures++; $display("FAIL load_stall1 got=%0b/%0b exp=1/0", bus.stall, bus.pc_sel); end
    tick();
    bus.mem_reg_write = 0; bus.mem_mem_read = 0; bus.mem_rd = 0;
    #2;
    checks++; if (bus.stall !== 1'b0 || bus.fwd_b_sel !== 1'b0) begin failures++; $display("FAIL load_resolve got=%0b fwdb=%0b exp=0/0", bus.stall, bus.fwd_b_sel); end
    checks++; if (bus.pc_sel !== 1'b0 || bus.flush_if !== 1'b0 || bus.pc_target !== 32'hC0) begin
      failures++; $display("FAIL load_nottaken got=%0b%0b/%0h exp=00/c0", bus.pc_sel, bus.flush_if, bus.pc_target); end
    tick();
    clear_inputs();
    checks++; if (bus.br_count !== 16'd3 || bus.taken_count !== 16'd2 || bus.last_taken !== 1'b0) begin
      failures++; $display("FAIL load_counts got=%0d/%0d/%0b exp=3/2/0", bus.br_count, bus.taken_count, bus.last_taken); end
  endtask

  task automatic test_r0();
    bus.br_valid = 1; bus.rs = 0; bus.rt = 7; bus.cmp_out = 1; bus.br_target = 32'h100;
    bus.ex_reg_write = 1; bus.ex_rd = 0; bus.mem_reg_write = 1; bus.mem_rd = 0;
    #2;
    checks++; if (bus.stall !== 1'b0 || bus.fwd_a_sel !== 1'b0) begin failures++; $display("FAIL r0_nohaz got=%0b fwda=%0b exp=0/0", bus.stall, bus.fwd_a_sel); end
    checks++; if (bus.pc_sel !== 1'b1) begin failures++; $display("FAIL r0_resolve got=%0b exp=1", bus.pc_sel); end
    tick();
    clear_inputs();
    checks++; if (bus.br_count !== 16'd4 || bus.taken_count !== 16'd3) begin failures++; $display("FAIL r0_counts got=%0d/%0d exp=4/3", bus.br_count, bus.taken_count); end
  endtask

  task automatic test_max_not_sum();
    bus.br_valid = 1; bus.rs = 3; bus.rt = 4; bus.cmp_out = 1; bus.br_target = 32'h140;
    bus.ex_reg_write = 1; bus.ex_rd = 3;
    bus.mem_reg_write = 1; bus.mem_mem_read = 1; bus.mem_rd = 4;
    #2;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL max_stall got=%0b exp=1", bus.stall); end
    tick();
    bus.ex_reg_write = 0; bus.ex_rd = 0;
    bus.mem_reg_write = 1; bus.mem_mem_read = 0; bus.mem_rd = 3;
    #2;
    checks++; if (bus.stall !== 1'b0 || bus.fwd_a_sel !== 1'b1 || bus.pc_sel !== 1'b1) begin
      failures++; $display("FAIL max_resolve got=stall%0b fwda%0b pcsel%0b exp=0/1/1", bus.stall, bus.fwd_a_sel, bus.pc_sel); end
    tick();
    clear_inputs();
    checks++; if (bus.br_count !== 16'd5 || bus.taken_count !== 16'd4) begin failures++; $display("FAIL max_counts got=%0d/%0d exp=5/4", bus.br_count, bus.taken_count); end
  endtask

  task automatic test_flush();
    bus.br_valid = 1; bus.rs = 1; bus.rt = 4; bus.cmp_out = 1; bus.br_target = 32'h180;
    bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_rd = 4;
    tick();
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    bus.mem_reg_write = 1; bus.mem_mem_read = 1; bus.mem_rd = 4; bus.flush_in = 1;
    tick();
    clear_inputs();
    #2;
    checks++; if (bus.stall !== 1'b0 || bus.pc_sel !== 1'b0) begin failures++; $display("FAIL flush_stall_drop got=%0b/%0b exp=0/0", bus.stall, bus.pc_sel); end
    // Resolvable branch colliding with flush_in in IDLE
    bus.br_valid = 1; bus.rs = 2; bus.rt = 6; bus.cmp_out = 1; bus.br_target = 32'h1C0; bus.flush_in = 1;
    #2;
    checks++; if (bus.pc_sel !== 1'b0 || bus.flush_if !== 1'b0 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL flush_resolve got=%0b%0b%0b exp=000", bus.pc_sel, bus.flush_if, bus.stall); end
    tick();
    bus.ex_reg_write = 1; bus.ex_rd = 2;
    #2;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_masks_stall got=%0b exp=0", bus.stall); end
    tick();
    clear_inputs();
    checks++; if (bus.br_count !== 16'd5 || bus.taken_count !== 16'd4) begin failures++; $display("FAIL flush_counts got=%0d/%0d exp=5/4", bus.br_count, bus.taken_count); end
  endtask

  task automatic test_reset_mid_stall();
    bus.br_valid = 1; bus.rs = 1; bus.rt = 4; bus.cmp_out = 1; bus.br_target = 32'h200;
    bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_rd = 4;
    tick();
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    bus.mem_reg_write = 1; bus.mem_mem_read = 1; bus.mem_rd = 4;
    #2;
    rst_n = 0;
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.pc_sel !== 1'b0 || bus.fwd_a_sel !== 1'b0 || bus.fwd_b_sel !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%0b%0b%0b%0b exp=0000", bus.stall, bus.pc_sel, bus.fwd_a_sel, bus.fwd_b_sel); end
    checks++; if (bus.br_count !== 16'd0 || bus.taken_count !== 16'd0 || bus.pc_target !== 32'd0) begin
      failures++; $display("FAIL rstmid_counts got=%0d/%0d/%0h exp=0/0/0", bus.br_count, bus.taken_count, bus.pc_target); end
    tick();
    clear_inputs();
    rst_n = 1;
    tick();
    bus.br_valid = 1; bus.rs = 1; bus.rt = 2; bus.cmp_out = 0; bus.br_target = 32'h240;
    #2;
    checks++; if (bus.stall !== 1'b0 || bus.pc_target !== 32'h240) begin failures++; $display("FAIL rstmid_idle got=%0b/%0h exp=0/240", bus.stall, bus.pc_target); end
    tick();
    clear_inputs();
    checks++; if (bus.br_count !== 16'd1 || bus.taken_count !== 16'd0) begin failures++; $display("FAIL rstmid_recount got=%0d/%0d exp=1/0", bus.br_count, bus.taken_count); end
  endtask

  task automatic test_saturation();
    bus.br_valid = 1; bus.rs = 8; bus.rt = 9; bus.cmp_out = 1; bus.br_target = 32'h300;
    for (int i = 0; i < 10; i++) tick();
    clear_inputs();
    checks++; if (sbus.br_count !== 3'd7 || sbus.taken_count !== 3'd7) begin failures++; $display("FAIL sat_small got=%0d/%0d exp=7/7", sbus.br_count, sbus.taken_count); end
    checks++; if (bus.br_count !== 16'd11 || bus.taken_count !== 16'd10 || bus.last_taken !== 1'b1) begin
      failures++; $display("FAIL sat_wide got=%0d/%0d/%0b exp=11/10/1", bus.br_count, bus.taken_count, bus.last_taken); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_no_hazard();
    test_ex_alu();
    test_ex_load();
    test_r0();
    test_max_not_sum();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
